// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

   typedef enum logic {
      REQ,
      DRAIN
   } fetch_state_t;

   localparam logic [31:0] BUBBLE_INSTR     = 32'h0;
   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry holding register between instruction memory and IF/ID.
// Priority per edge: clear > load > consume.
module fetch_buffer
   import if_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        consume,
   input  logic        clear,
   input  logic [31:0] load_instr,
   input  logic [31:0] load_pc_plus4,
   output logic        buf_valid,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] instr_o
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_valid  <= 1'b0;
         pc_plus4_o <= '0;
         instr_o    <= BUBBLE_INSTR;
      end else if (clear) begin
         buf_valid <= 1'b0;
      end else if (load) begin
         buf_valid  <= 1'b1;
         pc_plus4_o <= load_pc_plus4;
         instr_o    <= load_instr;
      end else if (consume) begin
         buf_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to imem over req/ready and feeds IF/ID.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module fetch_unit
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] instr_o,
`ifdef IF_PERF_CNT_EN
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] redirect_cnt_o,
`endif
   output logic        if_flush_o
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q;
   logic [31:0]  req_addr_q;
   logic         buf_valid;
   logic         consume;
   logic         load;

   assign consume    = buf_valid & ~stall_i & ~branch_taken_i;
   assign load       = (state_q == REQ) & imem_req_o & imem_ready_i & ~branch_taken_i;
   assign if_flush_o = branch_taken_i | (~buf_valid & ~stall_i);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= REQ;
      else       state_q <= state_d;
   end

   // A redirect with the request still in flight must wait out the stale response.
   always_comb begin
      state_d = state_q;
      case (state_q)
         REQ:     if (branch_taken_i & imem_req_o & ~imem_ready_i) state_d = DRAIN;
         DRAIN:   if (imem_ready_i) state_d = REQ;
         default: state_d = REQ;
      endcase
   end

   always_comb begin
      imem_req_o  = 1'b0;
      imem_addr_o = pc_q;
      case (state_q)
         REQ: begin
            imem_req_o  = ~buf_valid | consume;
            imem_addr_o = pc_q;
         end
         DRAIN: begin
            imem_req_o  = 1'b1;
            imem_addr_o = req_addr_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q       <= {RESET_PC[31:2], 2'b00};
         req_addr_q <= {RESET_PC[31:2], 2'b00};
      end else begin
         if (branch_taken_i) pc_q <= {branch_target_i[31:2], 2'b00};
         else if (load)      pc_q <= pc_q + PC_STEP;
         if (state_q == REQ) req_addr_q <= pc_q;
      end
   end

   fetch_buffer u_buf (
      .clk           (clk),
      .reset         (reset),
      .load          (load),
      .consume       (consume),
      .clear         (branch_taken_i),
      .load_instr    (imem_rdata_i),
      .load_pc_plus4 (imem_addr_o + PC_STEP),
      .buf_valid     (buf_valid),
      .pc_plus4_o    (pc_plus4_o),
      .instr_o       (instr_o)
   );

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_cnt_o    <= '0;
         stall_cnt_o    <= '0;
         redirect_cnt_o <= '0;
      end else begin
         if (consume)               fetch_cnt_o    <= fetch_cnt_o + 32'd1;
         if (stall_i & buf_valid)   stall_cnt_o    <= stall_cnt_o + 32'd1;
         if (branch_taken_i)        redirect_cnt_o <= redirect_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model with programmable latency and a capture scoreboard.
module tb_fetch_unit;

   typedef struct {
      logic [31:0] pc4;
      logic [31:0] instr;
   } cap_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_i;
   logic        branch_taken_i;
   logic [31:0] branch_target_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ready_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] pc_plus4_o;
   logic [31:0] instr_o;
   logic        if_flush_o;

   int unsigned mem_lat;
   int unsigned wait_cnt;
   int          n_vec = 0;
   int          n_err = 0;
   cap_t        exp_q[$];

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
      .clk             (clk),
      .reset           (reset),
      .stall_i         (stall_i),
      .branch_taken_i  (branch_taken_i),
      .branch_target_i (branch_target_i),
      .imem_req_o      (imem_req_o),
      .imem_addr_o     (imem_addr_o),
      .imem_ready_i    (imem_ready_i),
      .imem_rdata_i    (imem_rdata_i),
      .pc_plus4_o      (pc_plus4_o),
      .instr_o         (instr_o),
      .if_flush_o      (if_flush_o)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_5A5A;
   endfunction

   // Memory answers after mem_lat cycles of an unbroken request.
   always @(posedge clk) begin
      if (reset || !imem_req_o || imem_ready_i) wait_cnt <= 0;
      else                                      wait_cnt <= wait_cnt + 1;
   end
   assign imem_ready_i = imem_req_o && (wait_cnt >= mem_lat);
   assign imem_rdata_i = mem_word(imem_addr_o);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] pc4, input logic [31:0] a);
      cap_t c;
      c.pc4   = pc4;
      c.instr = mem_word(a);
      exp_q.push_back(c);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // IF/ID captures whenever the slot is neither stalled, redirected nor flushed.
   always @(negedge clk) begin
      if (!reset && !stall_i && !branch_taken_i && !if_flush_o) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL capture_unexpected: observed pc4 %h expected none", pc_plus4_o);
         end else begin
            cap_t e;
            e = exp_q.pop_front();
            chk("cap_pc4", pc_plus4_o, e.pc4);
            chk("cap_instr", instr_o, e.instr);
         end
      end
   end

   initial begin
      reset = 1'b1; stall_i = 1'b0; branch_taken_i = 1'b0; branch_target_i = '0; mem_lat = 0;
      repeat (2) @(posedge clk);
      #1;
      smp();
      chk("rst_pc4", pc_plus4_o, 32'h0);
      chk("rst_instr", instr_o, 32'h0);
      chk("rst_addr", imem_addr_o, 32'h100);
      chk("rst_flush", {31'd0, if_flush_o}, 32'd1);

      // zero-wait streaming
      cyc(); reset = 1'b0;
      push(32'h104, 32'h100); push(32'h108, 32'h104); push(32'h10C, 32'h108);
      smp(); chk("A_addr", imem_addr_o, 32'h100); chk("A_flush", {31'd0, if_flush_o}, 32'd1);
             chk("A_req", {31'd0, imem_req_o}, 32'd1);
      cyc(); smp(); chk("B_addr", imem_addr_o, 32'h104); chk("B_flush", {31'd0, if_flush_o}, 32'd0);
      cyc(); smp(); chk("C_addr", imem_addr_o, 32'h108);

      // stall with full buffer
      cyc(); stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("stall_pc4", pc_plus4_o, 32'h10C);
         chk("stall_instr", instr_o, mem_word(32'h108));
         chk("stall_req", {31'd0, imem_req_o}, 32'd0);
         chk("stall_flush", {31'd0, if_flush_o}, 32'd0);
         if (i < 2) cyc();
      end
      cyc(); stall_i = 1'b0;
      push(32'h110, 32'h10C); push(32'h114, 32'h110);
      smp(); chk("G_addr", imem_addr_o, 32'h10C);

      // two-cycle memory latency
      cyc(); mem_lat = 2;
      smp(); chk("H_addr", imem_addr_o, 32'h110);
      cyc(); smp(); chk("I_addr", imem_addr_o, 32'h110); chk("I_flush", {31'd0, if_flush_o}, 32'd1);
      cyc(); smp(); chk("J_addr", imem_addr_o, 32'h110); chk("J_flush", {31'd0, if_flush_o}, 32'd1);
      cyc(); smp(); chk("K_addr", imem_addr_o, 32'h114);

      // redirect while a request is pending
      cyc(); branch_taken_i = 1'b1; branch_target_i = 32'h0000_0203;
      push(32'h204, 32'h200);
      smp(); chk("L_flush", {31'd0, if_flush_o}, 32'd1); chk("L_addr", imem_addr_o, 32'h114);
      cyc(); branch_taken_i = 1'b0;
      smp(); chk("M_req", {31'd0, imem_req_o}, 32'd1); chk("M_drain_addr", imem_addr_o, 32'h114);
      cyc(); smp(); chk("N_addr", imem_addr_o, 32'h200);
      cyc(); smp(); chk("O_flush", {31'd0, if_flush_o}, 32'd1);
      cyc(); smp(); chk("P_addr", imem_addr_o, 32'h200);
      cyc(); mem_lat = 0;
      smp(); chk("Q_addr", imem_addr_o, 32'h204);

      // redirect and stall together
      cyc(); stall_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 32'h300;
      push(32'h304, 32'h300);
      smp(); chk("R_flush", {31'd0, if_flush_o}, 32'd1); chk("R_req", {31'd0, imem_req_o}, 32'd0);
      cyc(); stall_i = 1'b0; branch_taken_i = 1'b0;
      smp(); chk("S_flush", {31'd0, if_flush_o}, 32'd1); chk("S_addr", imem_addr_o, 32'h300);
      cyc(); smp(); chk("T_addr", imem_addr_o, 32'h304);

      // PC wrap at the top of the address space
      cyc(); branch_taken_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
      push(32'h0, 32'hFFFF_FFFC); push(32'h4, 32'h0);
      smp(); chk("U_flush", {31'd0, if_flush_o}, 32'd1);
      cyc(); branch_taken_i = 1'b0;
      smp(); chk("V_addr", imem_addr_o, 32'hFFFF_FFFC);
      cyc(); smp(); chk("W_addr", imem_addr_o, 32'h0); chk("W_pc4", pc_plus4_o, 32'h0);
      cyc(); smp(); chk("X_addr", imem_addr_o, 32'h4);

      cyc(); stall_i = 1'b1;
      smp();
      chk("sb_pending", exp_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
